data_mem_responder: RTL

- Multi-cycle data-memory responder: the memory-side end of the CPU load/store interface.
- Accepts one load or store request per valid/ready handshake and performs byte, halfword or word access using RISC-V funct3 encoding.
- Returns load data sign- or zero-extended, after a fixed latency, on a response valid/ready handshake.
- Sits between the core's memory stage and the data RAM; replaces the zero-latency combinational memory once the core is pipelined.

---
 rtl/data_mem_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: one outstanding request,
// byte/half/word access at the acceptance edge, response after a fixed latency.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 131072,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int         WORDS    = DEPTH_BYTES / 4;
    localparam int         IDX_W    = ADDR_WIDTH - 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [3:0]            r_cnt;

    logic [31:0]           r_mem [WORDS];

    logic                  w_accept;
    logic                  w_err;
    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_idx;
    logic [31:0]           w_rword;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;

    // Misalignment, out-of-range, illegal funct3 and unsigned-store encodings.
    function automatic logic f_err(input logic we, input logic [31:0] addr,
                                   input logic [2:0] f3);
        logic e;
        case (f3)
            3'b000, 3'b100: e = 1'b0;
            3'b001, 3'b101: e = addr[0];
            3'b010:         e = |addr[1:0];
            default:        e = 1'b1;
        endcase
        if (we && f3[2])
            e = 1'b1;
        if (addr >= 32'(DEPTH_BYTES))
            e = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'b0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'b0, h};
            3'b010:  r = word;
            default: r = 32'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] lane, input logic [2:0] f3);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across lanes; the byte enables pick the live ones.
    function automatic logic [31:0] f_wdata(input logic [31:0] d, input logic [2:0] f3);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && r_req_ready && req_valid;
    assign w_err     = f_err(req_we, req_addr, req_funct3);
    assign w_wr_en   = w_accept && req_we && !w_err;
    assign w_idx     = req_addr[ADDR_WIDTH-1:2];
    assign w_rword   = r_mem[w_idx];
    assign w_be      = f_be(req_addr[1:0], req_funct3);
    assign w_wdata   = f_wdata(req_wdata, req_funct3);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_err       <= w_err;
                        r_rdata     <= (w_err || req_we) ? '0
                                       : f_load(w_rword, req_addr[1:0], req_funct3);
                        r_cnt       <= CNT_INIT;
                        if (LATENCY > 1) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_rdata     <= '0;
                        r_err       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
